// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register: valid bit, data and control payloads, stall/flush, NOP bubbles.
// Define PIPE_STAGE_PERF_EN to add saturating stall_cnt / bubble_cnt performance counters.
module pipe_stage_reg #(
    parameter int                 DATA_W              = 64,
    parameter int                 CTRL_W              = 32,
    parameter logic [CTRL_W-1:0]  NOP_CTRL            = {CTRL_W{1'b0}},
    parameter int                 ZERO_DATA_ON_BUBBLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
`ifdef PIPE_STAGE_PERF_EN
    output logic [15:0]       stall_cnt,
    output logic [15:0]       bubble_cnt,
`endif
    output logic [CTRL_W-1:0] ctrl_out
);

    logic              valid_d, valid_q;
    logic [DATA_W-1:0] data_d,  data_q;
    logic [CTRL_W-1:0] ctrl_d,  ctrl_q;
    logic              kill_act;
    logic              hold_act;

    // Flush beats stall; an idle upstream takes the same path as a flush.
    assign kill_act = flush || (!stall && !valid_in);
    assign hold_act = !flush && stall;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (kill_act) begin
            valid_d = 1'b0;
            ctrl_d  = NOP_CTRL;
            if (ZERO_DATA_ON_BUBBLE != 0) begin
                data_d = '0;
            end
        end else if (!hold_act) begin
            valid_d = 1'b1;
            data_d  = data_in;
            ctrl_d  = ctrl_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= NOP_CTRL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign ctrl_out  = ctrl_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] stall_cnt_d,  stall_cnt_q;
    logic [15:0] bubble_cnt_d, bubble_cnt_q;

    // Both counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (hold_act && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (kill_act && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
